pc_fetch_unit: RTL

//  Program-counter register and instruction-fetch sequencer; the stage that consumes the branch/jump

---
 rtl/pc_fetch_unit.sv | 113 +++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer: issues instruction-memory reads with a busywait
// handshake, delivers fetched words to IF/ID, and squashes wrong-path fetches on redirect.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             BRANCH_TAKEN,
  input  logic [31:0]      BRANCH_TARGET,
  input  logic             STALL,
  output logic             IMEM_READ,
  output logic [31:0]      IMEM_ADDRESS,
  input  logic             IMEM_BUSYWAIT,
  input  logic [31:0]      IMEM_INSTRUCTION,
  output logic [31:0]      PC,
  output logic [31:0]      PC_PLUS_4,
  output logic [31:0]      INSTRUCTION,
  output logic             INSTR_VALID,
  output logic             FLUSH,
  output logic [CNT_W-1:0] MISS_CYCLES
);

  typedef enum logic [1:0] {BOOT, FETCH, DRAIN, HOLD} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] saved_target;
  logic [31:0] target;
  logic        miss_cycle;

  assign target       = {BRANCH_TARGET[31:2], 2'b00};
  assign IMEM_READ    = (state == FETCH) || (state == DRAIN);
  assign IMEM_ADDRESS = fetch_pc;
  assign PC_PLUS_4    = PC + 32'd4;
  assign miss_cycle   = IMEM_READ && IMEM_BUSYWAIT;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state        <= BOOT;
      fetch_pc     <= RESET_VECTOR;
      PC           <= RESET_VECTOR;
      INSTRUCTION  <= NOP_INSTR;
      INSTR_VALID  <= 1'b0;
      FLUSH        <= 1'b0;
      MISS_CYCLES  <= '0;
      saved_target <= '0;
    end else begin
      FLUSH <= 1'b0;
      if (miss_cycle && (MISS_CYCLES != '1))
        MISS_CYCLES <= MISS_CYCLES + CNT_W'(1);

      unique case (state)
        BOOT: begin
          state <= FETCH;
          if (BRANCH_TAKEN) begin
            fetch_pc    <= target;
            INSTR_VALID <= 1'b0;
            FLUSH       <= 1'b1;
          end
        end

        FETCH: begin
          if (BRANCH_TAKEN) begin
            INSTR_VALID <= 1'b0;
            FLUSH       <= 1'b1;
            // A pending miss cannot be withdrawn: park the target until the stale reply returns.
            if (IMEM_BUSYWAIT) begin
              saved_target <= target;
              state        <= DRAIN;
            end else begin
              fetch_pc <= target;
            end
          end else if (STALL) begin
            state <= HOLD;
          end else if (!IMEM_BUSYWAIT) begin
            INSTRUCTION <= IMEM_INSTRUCTION;
            PC          <= fetch_pc;
            INSTR_VALID <= 1'b1;
            fetch_pc    <= fetch_pc + 32'd4;
          end
        end

        DRAIN: begin
          if (BRANCH_TAKEN) begin
            saved_target <= target;
            INSTR_VALID  <= 1'b0;
            FLUSH        <= 1'b1;
          end
          if (!IMEM_BUSYWAIT) begin
            fetch_pc <= BRANCH_TAKEN ? target : saved_target;
            state    <= FETCH;
          end
        end

        HOLD: begin
          if (BRANCH_TAKEN) begin
            fetch_pc    <= target;
            INSTR_VALID <= 1'b0;
            FLUSH       <= 1'b1;
            state       <= FETCH;
          end else if (!STALL) begin
            state <= FETCH;
          end
        end

        default: state <= BOOT;
      endcase
    end
  end

endmodule
